// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parameterised parallel-in/serial-out shift register
// Optional build macro: PISO_LSB_FIRST_EN selects LSB-first serialisation (default MSB-first).

module piso_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] parallel_in,
    output logic         serial_out
);

    logic [N-1:0] sreg;
    logic [N-1:0] sreg_shifted;

`ifdef PISO_LSB_FIRST_EN
    // Bits leave from position 0; zeros enter at the top.
    assign sreg_shifted = {1'b0, sreg[N-1:1]};
    assign serial_out   = sreg[0];
`else
    assign sreg_shifted = {sreg[N-2:0], 1'b0};
    assign serial_out   = sreg[N-1];
`endif

    // Reset wins over load, load wins over shift; a load mid-word discards the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= parallel_in;
        end else begin
            sreg <= sreg_shifted;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb/tb_piso_shift_reg.sv - scoreboard bench for piso_shift_reg (N=4 and N=8 instances)

module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] parallel_in = '0;
    logic       serial_out;

    logic       reset8 = 1'b0;
    logic       load8 = 1'b0;
    logic [7:0] parallel_in8 = '0;
    logic       serial_out8;

    int tests_run = 0;
    int tests_failed = 0;

    logic exp_q[$];
    logic exp8_q[$];

    always #5 clk = ~clk;

    piso_shift_reg #(.N(4)) piso (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .parallel_in (parallel_in),
        .serial_out  (serial_out)
    );

    piso_shift_reg #(.N(8)) piso8 (
        .clk         (clk),
        .reset       (reset8),
        .load        (load8),
        .parallel_in (parallel_in8),
        .serial_out  (serial_out8)
    );

    // One clock edge on the N=4 instance; the expected post-edge output goes to the scoreboard.
    task automatic step(input logic r, input logic l, input logic [3:0] p, input logic e);
        reset = r;
        load = l;
        parallel_in = p;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic step8(input logic r, input logic l, input logic [7:0] p, input logic e);
        reset8 = r;
        load8 = l;
        parallel_in8 = p;
        @(posedge clk);
        #1;
        exp8_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            tests_run++;
            if (serial_out !== e) begin
                tests_failed++;
                $display("FAIL n4_serial_out at %0t: got %b expected %b", $time, serial_out, e);
            end
        end
        if (exp8_q.size() > 0) begin
            logic e8;
            e8 = exp8_q.pop_front();
            tests_run++;
            if (serial_out8 !== e8) begin
                tests_failed++;
                $display("FAIL n8_serial_out at %0t: got %b expected %b", $time, serial_out8, e8);
            end
        end
    end

    // Hand-computed bit sequences that depend on shift direction.
`ifdef PISO_LSB_FIRST_EN
    localparam logic [3:0] T2_SEQ = 4'b1101;  // 1011 LSB-first: 1,1,0,1
    localparam logic [2:0] T3_SEQ = 3'b000;   // 1000 LSB-first: 0,0,0
    localparam logic [1:0] T4_SEQ = 2'b11;    // 1011 LSB-first: 1,1
`else
    localparam logic [3:0] T2_SEQ = 4'b1011;
    localparam logic [2:0] T3_SEQ = 3'b100;
    localparam logic [1:0] T4_SEQ = 2'b10;
`endif

    initial begin
        logic [3:0] t2;
        logic [2:0] t3;
        logic [1:0] t4;
        t2 = T2_SEQ;
        t3 = T3_SEQ;
        t4 = T4_SEQ;

        // Reset, then reset overriding load.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step8(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 4'hF, 1'b0);
        step(1'b1, 1'b1, 4'hF, 1'b0);

        // Single word, then zero tail; parallel_in is don't-care while load=0.
        step(1'b0, 1'b1, 4'b1011, t2[3]);
        step(1'b0, 1'b0, 4'hF, t2[2]);
        step(1'b0, 1'b0, 4'h5, t2[1]);
        step(1'b0, 1'b0, 4'hA, t2[0]);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'($urandom), 1'b0);

        // Reload mid-word: 0110 reads the same either direction.
        step(1'b0, 1'b1, 4'b1000, t3[2]);
        step(1'b0, 1'b0, 4'h0, t3[1]);
        step(1'b0, 1'b0, 4'h0, t3[0]);
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        step(1'b0, 1'b0, 4'hF, 1'b1);
        step(1'b0, 1'b0, 4'hF, 1'b1);
        step(1'b0, 1'b0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 4'hF, 1'b0);
        step(1'b0, 1'b0, 4'hF, 1'b0);

        // Reset mid-shift discards the remaining bits.
        step(1'b0, 1'b1, 4'b1011, t4[1]);
        step(1'b0, 1'b0, 4'h0, t4[0]);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'hF, 1'b0);

        // Load held high: 1001 is symmetric so both directions give 1,1,1 then 0,0,1,0.
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);

        // N=8: A5 is bit-symmetric so both directions give 1,0,1,0,0,1,0,1.
        step8(1'b0, 1'b1, 8'hA5, 1'b1);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);
        step8(1'b0, 1'b0, 8'hFF, 1'b1);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);
        step8(1'b0, 1'b0, 8'hFF, 1'b1);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);
        step8(1'b0, 1'b0, 8'hFF, 1'b1);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);
        step8(1'b0, 1'b0, 8'hFF, 1'b0);

        // Let the monitor drain; anything left unchecked is a failure.
        repeat (3) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", exp_q.size(), exp8_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
